// File: rtl/popcount_arbiter.sv
// Round-robin arbiter in front of a shared bit-serial ones counter. The granted
// requester's word is shifted through a 1-bit accumulator over W cycles and the
// result is returned with a one-cycle valid/ack pulse.
module popcount_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 7,
  localparam int CW   = $clog2(W + 1),
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   data,
  output logic [NREQ-1:0]     ack,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  output logic                valid,
  output logic [CW-1:0]       count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [GW-1:0]   r_ptr;
  logic [W-1:0]    r_sh;
  logic [CW-1:0]   r_acc;
  logic [CW-1:0]   r_bitcnt;
  logic [NREQ-1:0] r_ack;
  logic [GW-1:0]   r_grant;
  logic            r_busy;
  logic            r_valid;
  logic [CW-1:0]   r_count;

  logic            w_hi_found;
  logic [GW-1:0]   w_hi_id;
  logic            w_lo_found;
  logic [GW-1:0]   w_lo_id;
  logic            w_found;
  logic [GW-1:0]   w_win_id;
  logic [W-1:0]    w_win_data;
  logic [CW-1:0]   w_acc_next;
  logic [NREQ-1:0] w_onehot;

  // Round robin: lowest set request above the pointer wins; if none, wrap to
  // the lowest set request overall (which may be the pointer itself).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_hi_found = 1'b0;
    w_hi_id    = '0;
    w_lo_found = 1'b0;
    w_lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_found = 1'b1;
        w_lo_id    = GW'(i);
        if (i > int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_id    = GW'(i);
        end
      end
    end
    w_found  = w_lo_found;
    w_win_id = w_hi_found ? w_hi_id : w_lo_id;
  end

  always_comb begin
    w_win_data = '0;
    w_onehot   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == w_win_id) w_win_data = data[i*W +: W];
      w_onehot[i] = (GW'(i) == r_grant);
    end
  end

  assign w_acc_next = r_acc + CW'(r_sh[0]);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= GW'(NREQ - 1);
      r_sh     <= '0;
      r_acc    <= '0;
      r_bitcnt <= '0;
      r_ack    <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_ack   <= '0;
          if (w_found) begin
            r_sh     <= w_win_data;
            r_grant  <= w_win_id;
            r_ptr    <= w_win_id;
            r_acc    <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_COUNT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_COUNT: begin
          r_acc    <= w_acc_next;
          r_sh     <= r_sh >> 1;
          r_bitcnt <= r_bitcnt + CW'(1);
          // Fixed W-cycle latency; outputs are loaded on entry to DONE so
          // they are visible during the DONE cycle itself.
          if (r_bitcnt == CW'(W - 1)) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_count <= w_acc_next;
            r_ack   <= w_onehot;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack      = r_ack;
  assign grant_id = r_grant;
  assign busy     = r_busy;
  assign valid    = r_valid;
  assign count    = r_count;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Self-checking bench for popcount_arbiter: directed scenarios push expected
// (requester, count, cycle) records; a monitor pops them on every valid pulse.
module tb_popcount_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 7;
  localparam int CW   = 3;
  localparam int GW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              valid;
  logic [CW-1:0]     count;

  typedef struct {
    int id;
    int cnt;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   c;

  popcount_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .valid    (valid),
    .count    (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_one(input int id, input logic [W-1:0] word);
    int c0;
    data[id*W +: W] = word;
    req = NREQ'(1) << id;
    c0 = cyc;
    q.push_back('{id, $countones(word), c0 + 8});
    repeat (8) step();
    req = '0;
    step();
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding record.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid", q.size(), 1);
      end else begin
        e = q.pop_front();
        check("grant_id", grant_id, e.id);
        check("count", count, e.cnt);
        check("ack", ack, 1 << e.id);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    do_reset();
    check("rst_ack", ack, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);

    // Single request from requester 2
    data[2*W +: W] = 7'b1011001;
    req = 4'b0100;
    c = cyc;
    q.push_back('{2, 4, c + 8});
    for (int k = 1; k <= 9; k++) begin
      step();
      @(negedge clk);
      check($sformatf("busy_c%0d", k), busy, (k <= 8) ? 1 : 0);
      if (k == 1) check("grant_c1", grant_id, 2);
      if (k == 8) req = '0;
      if (k == 9) begin
        check("valid_c9", valid, 0);
        check("ack_c9", ack, 0);
      end
    end

    // Extremes
    run_one(0, 7'h7F);
    run_one(0, 7'h00);

    // Round-robin fairness with all four requesting
    do_reset();
    data = {7'h0F, 7'h1F, 7'h3F, 7'h7F};
    req = 4'b1111;
    c = cyc;
    for (int j = 0; j < 5; j++) q.push_back('{j % 4, 7 - (j % 4), c + 8 + 9 * j});
    repeat (45) step();
    req = '0;
    step();

    // Inputs changed mid-transaction must not affect the result
    data[W +: W] = 7'b0000111;
    req = 4'b0010;
    c = cyc;
    q.push_back('{1, 3, c + 8});
    repeat (3) step();
    req = '0;
    data[W +: W] = 7'h7F;
    repeat (6) step();

    // Reset mid-COUNT aborts the transfer and restarts priority at 0
    data[0 +: W] = 7'b0110011;
    req = 4'b0011;
    c = cyc;
    repeat (4) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_ack", ack, 0);
    check("abort_count", count, 0);
    check("abort_grant", grant_id, 0);
    rst = 1'b0;
    q.push_back('{0, 4, c + 13});
    step();
    @(negedge clk);
    check("post_rst_grant", grant_id, 0);
    check("post_rst_busy", busy, 1);
    repeat (7) step();
    req = '0;
    step();

    // Solo requester held for 30 cycles is re-granted every 9 cycles
    data[3*W +: W] = 7'b1010101;
    req = 4'b1000;
    c = cyc;
    for (int j = 0; j < 4; j++) q.push_back('{3, 4, c + 8 + 9 * j});
    repeat (30) step();
    req = '0;
    repeat (6) step();

    repeat (3) step();
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/popcount_arbiter.md
# popcount_arbiter

Shares one serial ones-counting unit among NREQ requesters, each presenting a W-bit word. A round-robin arbiter selects a requester, a controller FSM shifts the captured word through a 1-bit accumulator over W cycles, and the result is returned with a one-cycle valid/ack pulse. It sits in front of the ones-count / compare path, so several producers can use one counter instead of each carrying its own encoder.

## Interface
- NREQ, 4, number of requesters
- W, 7, data word width per requester
- CW, $clog2(W+1) (3 for W=7), count width; derived, do not override
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  request per requester; held until its ack
- data  input  NREQ*W  requester i word at data[i*W +: W]; must be stable in the grant cycle
- ack  output  NREQ  one-hot, one-cycle pulse to the serviced requester
- grant_id  output  $clog2(NREQ)  index of the requester being / last serviced
- busy  output  1  high while a transaction is in COUNT or DONE
- valid  output  1  one-cycle pulse; count is valid
- count  output  CW  number of 1 bits in the serviced word

## Operation
- All outputs are registered.
- Reset values: ack=0, grant_id=0, busy=0, valid=0, count=0, state=IDLE, rr pointer ptr=NREQ-1, accumulator=0, bit counter=0.
- The FSM has three states: IDLE, COUNT and DONE.
- IDLE:
  - If req is nonzero, pick the first set bit searching ptr+1, ptr+2, … (mod NREQ).
  - Capture that requester's word into shift register sh.
  - Set grant_id to the winner and ptr to the winner.
  - Clear acc and bit counter, set busy=1, go to COUNT.
  - Otherwise stay in IDLE with busy=0.
- COUNT:
  - Each cycle: acc <= acc + sh[0], sh <= sh >> 1, bitcnt++.
  - After exactly W cycles, go to DONE.
  - There is no early exit on sh==0; latency is fixed.
- DONE:
  - valid=1, count=acc, ack[grant_id]=1, busy=1 for exactly one cycle.
  - Next state is IDLE, which clears valid, ack and busy.
- count holds its last value until the next DONE. grant_id holds until the next grant.
- Arithmetic: acc is CW bits wide. The maximum value is W, which always fits, so overflow cannot occur.
- req and data are ignored outside IDLE. Dropping req or changing data during COUNT/DONE does not affect the result, and ack is still issued.
- A requester still asserting req in the IDLE cycle after its ack is treated as a new request. Round-robin ordering places it behind any other pending requester.
- rst during any state: on the next edge, all outputs and state return to reset values. The aborted transaction gets no valid/ack. Arbitration restarts with requester 0 as highest priority.

## Timing
- Cycle 0: IDLE samples req and captures data.
- Cycles 1..W: COUNT.
- Cycle W+1: DONE, with valid/ack high. This is cycle 8 for W=7.
- Cycle W+2: IDLE, the earliest next grant.
- Latency from the grant cycle to valid is W+1 cycles.
- Minimum period between grants is W+2 cycles (9 for W=7).
- valid and the ack bit are asserted in the same cycle, each for exactly one cycle.
- busy is high during cycles 1..W+1.

## Test plan
- Single request: reset, then req=4'b0100 with data[2]=7'b1011001 held. Required: grant_id=2 in cycle 1, busy high in cycles 1–8, and in cycle 8 valid=1, count=4, ack=4'b0100. All low in cycle 9.
- Extremes: req[0] with 7'h7F gives count=7. req[0] with 7'h00 gives count=0. Both take the same 8-cycle latency.
- Round-robin fairness: after reset, hold req=4'b1111 continuously with distinct data. Required: grants 0,1,2,3,0 at cycles 0,9,18,27,36. Each ack is for the matching index with the correct count.
- Mid-transaction input change: grant req[1] with 7'b0000111, then in cycle 3 drop req[1] and set data[1]=7'h7F. Required: cycle 8 gives count=3 and ack=4'b0010.
- Reset mid-COUNT: assert rst in cycle 4 of a transaction while req=4'b0011 is held. Required: the next cycle has all outputs 0 and no valid for the aborted transfer. After rst is released, requester 0 is granted first.
- Solo repeat: only req[3] is held high for 30 cycles with data 7'b1010101. Required: re-granted every 9 cycles, with valid pulses at cycles 8, 17 and 26, each with count=4 and ack=4'b1000.
